// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-cathode display.
// Drives one shared BCD decoder, with frame-synchronous updates, blinking and leading-zero blanking.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  blink_mask,
  input  logic        lz_suppress,
  output logic [3:0]  number,
  output logic [3:0]  digit_en,
  output logic        frame_start,
  output logic        load_ack
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TW-1:0] tick_r;
  logic [1:0]    idx_r;
  logic [15:0]   staging_r;
  logic [15:0]   shadow_r;
  logic          pending_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_on_r;

  logic          tick_wrap_s;
  logic          boundary_s;
  logic [3:0]    v_s;
  logic          dark_s;
  logic [3:0]    en_s;
  logic [3:0]    num_s;

  // Slot decode: current digit value, dark decision and next registered outputs
  always_comb begin
    tick_wrap_s = (tick_r == TW'(SCAN_DIV - 1));
    boundary_s  = tick_wrap_s && (idx_r == 2'd3);
    v_s         = shadow_r[{idx_r, 2'b00} +: 4];
    dark_s      = (v_s == 4'hA)
                | (blink_mask[idx_r] & ~blink_on_r)
                | (lz_suppress & (idx_r == 2'd3) & (v_s == 4'h0));
    en_s        = 4'b0000;
    num_s       = 4'hA;
    if (dark_s) begin
      num_s = 4'hA;
    end else begin
      num_s = v_s;
    end
    // The guard window keeps all cathodes off while the decoder settles on the new digit
    if ((tick_r >= TW'(GUARD)) && !dark_s) begin
      en_s = 4'b0001 << idx_r;
    end else begin
      en_s = 4'b0000;
    end
  end

  // Scan position counters: tick within the slot, idx across the four digits
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_r <= '0;
      idx_r  <= 2'd0;
    end else if (tick_wrap_s) begin
      tick_r <= '0;
      idx_r  <= idx_r + 2'd1;
    end else begin
      tick_r <= tick_r + TW'(1);
    end
  end

  // Blink phase advances once per frame and flips after BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else if (boundary_s) begin
      if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_r <= '0;
        blink_on_r  <= ~blink_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
    end
  end

  // Load handshake: staging collects loads, shadow only changes on the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      staging_r <= 16'hAAAA;
      shadow_r  <= 16'hAAAA;
      pending_r <= 1'b0;
    end else begin
      if (load) begin
        staging_r <= digits_in;
      end
      if (boundary_s) begin
        pending_r <= 1'b0;
        if (load) begin
          shadow_r <= digits_in;
        end else if (pending_r) begin
          shadow_r <= staging_r;
        end
      end else begin
        pending_r <= pending_r | load;
      end
    end
  end

  // Registered outputs towards the decoder and digit drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      number      <= 4'hA;
      digit_en    <= 4'b0000;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      number      <= num_s;
      digit_en    <= en_s;
      frame_start <= boundary_s;
      load_ack    <= boundary_s & (pending_r | load);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: an absolute-cycle reference model
// predicts every output cycle by cycle across directed and randomized scenarios.
module tb_display_scan_ctrl;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int BF = 2;
  localparam int FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;
  logic        lz_suppress = 1'b0;
  logic [3:0]  number;
  logic [3:0]  digit_en;
  logic        frame_start;
  logic        load_ack;

  int tests_run = 0;
  int failed    = 0;

  // model state: cycles since reset release, value shown this frame, staged load
  int          n;
  logic [15:0] shown;
  logic [15:0] staged;
  bit          pend;

  display_scan_ctrl #(.SCAN_DIV(S), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .blink_mask(blink_mask), .lz_suppress(lz_suppress), .number(number),
    .digit_en(digit_en), .frame_start(frame_start), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic model_init();
    n      = 0;
    shown  = 16'hAAAA;
    staged = 16'hAAAA;
    pend   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    model_init();
  endtask

  // One clock of stimulus; returns observed and predicted {number,digit_en,frame_start,load_ack}
  task automatic step(input logic ld, input logic [15:0] d,
                      output logic [9:0] got, output logic [9:0] exp);
    int idx, tk, f;
    bit boundary, blink_on, dark;
    logic [3:0] v;
    logic [3:0] e_en;
    load      = ld;
    digits_in = d;
    tk       = n % S;
    idx      = (n / S) % 4;
    f        = n / FRAME;
    boundary = ((n % FRAME) == FRAME - 1);
    blink_on = (((f / BF) % 2) == 0);
    v        = shown[idx*4 +: 4];
    dark     = (v == 4'hA) || (blink_mask[idx] && !blink_on) ||
               (lz_suppress && idx == 3 && v == 4'h0);
    e_en     = (!dark && tk >= G) ? (4'b0001 << idx) : 4'b0000;
    exp      = {dark ? 4'hA : v, e_en, boundary, boundary && (pend || ld)};
    if (ld) begin
      staged = d;
      pend   = 1'b1;
    end
    if (boundary && pend) begin
      shown = staged;
      pend  = 1'b0;
    end
    n++;
    @(posedge clk);
    #1;
    got = {number, digit_en, frame_start, load_ack};
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got, exp;
    int fs_cnt = 0;
    do_reset();
    tests_run++;
    if ({number, digit_en, frame_start, load_ack} !== {4'hA, 4'b0000, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL reset_values got=%h expected=%h", {number, digit_en, frame_start, load_ack}, 10'h280);
    end
    release_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 16'h0000, got, exp);
      fs_cnt += int'(got[1]);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL reset_idle cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
    tests_run++;
    if (fs_cnt !== 4) begin
      failed++;
      $display("FAIL reset_frame_count got=%0d expected=4", fs_cnt);
    end
  endtask

  task automatic test_load();
    logic [9:0] got, exp;
    int lit = 0;
    do_reset();
    release_reset();
    for (int i = 0; i < 48; i++) begin
      step(i == 5, 16'h1234, got, exp);
      if (got[5:2] == 4'b0001) lit++;
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL load_1234 cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
    tests_run++;
    if (lit !== 6) begin
      failed++;
      $display("FAIL load_enable_width got=%0d expected=6", lit);
    end
  endtask

  task automatic test_lz();
    logic [9:0] got, exp;
    do_reset();
    release_reset();
    lz_suppress = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 40) lz_suppress = 1'b0;
      step(i == 2, 16'h0945, got, exp);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL lz_suppress cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_blink();
    logic [9:0] got, exp;
    do_reset();
    release_reset();
    blink_mask = 4'b0011;
    for (int i = 0; i < 9 * FRAME; i++) begin
      step(i == 3, 16'h1234, got, exp);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL blink cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, exp;
    int acks = 0;
    do_reset();
    release_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == 2)              step(1'b1, 16'h1111, got, exp);
      else if (i == 9)         step(1'b1, 16'h2222, got, exp);
      else if (i == 2*FRAME-1) step(1'b1, 16'h5678, got, exp);
      else                     step(1'b0, 16'hFFFF, got, exp);
      acks += int'(got[0]);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL back_to_back cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
    tests_run++;
    if (acks !== 2) begin
      failed++;
      $display("FAIL back_to_back_acks got=%0d expected=2", acks);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got, exp;
    do_reset();
    release_reset();
    for (int i = 0; i < 7; i++) step(i == 5, 16'h4321, got, exp);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({number, digit_en, frame_start, load_ack} !== {4'hA, 4'b0000, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL reset_mid got=%h expected=%h", {number, digit_en, frame_start, load_ack}, 10'h280);
    end
    release_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0000, got, exp);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL reset_mid_after cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    logic [15:0] d;
    do_reset();
    release_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_suppress = 1'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d[15:12] = 4'h0;
      step($urandom_range(0, 9) == 0, d, got, exp);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL random cyc=%0d got=%h expected=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_lz();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
